// File: rtl/pattern_detector_pkg.sv
// pattern_detector_pkg: shared FSM state encoding for the serial pattern detector
package pattern_detector_pkg;
    typedef enum logic [1:0] {UNCFG, HUNT, HIT} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset || clr) count <= '0;
        else if (en && !(&count)) count <= count + 1'b1;
    end
endmodule

// File: rtl/pattern_detector.sv
// pattern_detector: configurable serial pattern matcher with Mealy/Moore and overlap modes
module pattern_detector #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cfg_moore,
    input  logic             in_valid,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);
    import pattern_detector_pkg::*;
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);
    localparam logic [FW-1:0] NEAR = FW'(PAT_W - 1);
    state_t state, state_nx;
    logic [PAT_W-1:0] pat, shifted;
    // only the newest PAT_W-1 bits can ever take part in a future match
    logic [PAT_W-2:0] hist;
    logic [FW-1:0] fill;
    logic overlap, moore, active, match;
    always_comb begin
        active   = in_valid && !cfg_load && state != UNCFG;
        shifted  = {hist, in};
        match    = active && fill >= NEAR && shifted == pat;
        out      = moore ? state == HIT : match;
        state_nx = cfg_load ? HUNT : state == UNCFG ? UNCFG : (moore && match) ? HIT : HUNT;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= UNCFG;
            pat     <= '0;
            overlap <= 1'b0;
            moore   <= 1'b0;
            hist    <= '0;
            fill    <= '0;
        end else begin
            state <= state_nx;
            if (cfg_load) begin
                pat     <= cfg_pattern;
                overlap <= cfg_overlap;
                moore   <= cfg_moore;
                hist    <= '0;
                fill    <= '0;
            end else if (active) begin
                hist <= shifted[PAT_W-2:0];
                fill <= (match && !overlap) ? '0 : fill == FULL ? fill : fill + 1'b1;
            end
        end
    end
    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cfg_load),
        .en    (match),
        .count (match_count)
    );
endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector: directed scoreboard bench for pattern_detector (PAT_W=4, CNT_W=2)
module tb_pattern_detector;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cfg_load = 1'b0;
    logic [3:0] cfg_pattern = '0;
    logic cfg_overlap = 1'b0;
    logic cfg_moore = 1'b0;
    logic in_valid = 1'b0;
    logic in = 1'b0;
    logic out;
    logic [1:0] match_count;
    int vectors = 0;
    int miscompares = 0;
    logic exp_q[$];
    logic want;

    pattern_detector #(.PAT_W(4), .CNT_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cfg_moore   (cfg_moore),
        .in_valid    (in_valid),
        .in          (in),
        .out         (out),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 reset = 1'b1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic cyc(input logic l, input logic v, input logic b, input logic e, input string tag);
        @(posedge clk);
        #1 cfg_load = l;
        in_valid = v;
        in = b;
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        vectors++;
        assert (out === want) else begin
            miscompares++;
            $error("FAIL %s: out=%b expected %b", tag, out, want);
        end
    endtask

    task automatic load(input logic [3:0] p, input logic ov, input logic mo, input logic v, input logic b);
        cfg_pattern = p;
        cfg_overlap = ov;
        cfg_moore = mo;
        cyc(1'b1, v, b, 1'b0, "load");
    endtask

    task automatic bits(input logic [7:0] pat_bits, input logic [7:0] exp_bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) cyc(1'b0, 1'b1, pat_bits[i], exp_bits[i], tag);
    endtask

    task automatic chk_cnt(input logic [1:0] e, input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle");
        vectors++;
        assert (match_count === e) else begin
            miscompares++;
            $error("FAIL %s: match_count=%0d expected %0d", tag, match_count, e);
        end
    endtask

    initial begin
        do_reset(2);
        chk_cnt(2'd0, "reset_cnt");
        bits(8'b1011, 8'b0000, 4, "uncfg");
        chk_cnt(2'd0, "uncfg_cnt");

        load(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        bits(8'b1011011, 8'b0001001, 7, "ov_mealy");
        chk_cnt(2'd2, "ov_mealy_cnt");

        load(4'b1011, 1'b0, 1'b0, 1'b1, 1'b1);
        bits(8'b1011011, 8'b0001000, 7, "nov_mealy");
        chk_cnt(2'd1, "nov_mealy_cnt");

        load(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, "moore_gap");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "moore_gap");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "moore_gap");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "moore_gap");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, "moore_gap");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, "moore_gap");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "moore_hit");
        chk_cnt(2'd1, "moore_cnt");

        load(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        bits(8'b11111, 8'b00001, 5, "moore_b2b");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "moore_stay");
        chk_cnt(2'd2, "moore_b2b_cnt");

        load(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        bits(8'b11111111, 8'b00011111, 8, "sat");
        chk_cnt(2'd3, "sat_cnt");

        load(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        bits(8'b1, 8'b0, 1, "pre_reload");
        load(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_cnt(2'd0, "reload_clr");
        bits(8'b011, 8'b000, 3, "post_reload");
        chk_cnt(2'd0, "post_reload_cnt");

        bits(8'b101, 8'b000, 3, "pre_reset");
        do_reset(1);
        bits(8'b1, 8'b0, 1, "post_reset_uncfg");
        load(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        bits(8'b1, 8'b0, 1, "post_reset");
        chk_cnt(2'd0, "post_reset_cnt");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
